window_filter: RTL and testbench

Sliding 2-D convolution stage placed directly downstream of the row line buffer. It consumes the buffer's column bus, which carries HEIGHT_NB vertically aligned pixels per beat. It shifts those columns into a HEIGHT_NB x WIDTH_NB window and applies runtime-loadable signed coefficients. For every fully populated window it emits one normalised pixel through a 3-stage multiply/add/shift pipeline.

---
 rtl/filter_pkg.sv | 37 +++
 rtl/window_filter_if.sv | 37 +++
 rtl/filter_mac.sv | 70 +++++++
 rtl/window_filter.sv | 203 ++++++++++++++++++++
 tb/tb_window_filter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared constants and helper functions for the window_filter slice.
//   - default window geometry and pixel/coefficient widths
//   - TAPS: number of coefficients for the default geometry
//   - product / sum width functions used by the MAC and the output stage
//   - tap_index: maps (row, col) of the window onto the flat coefficient index
// -----------------------------------------------------------------------------
package filter_pkg;

   localparam int HEIGHT_NB_DEF  = 3;
   localparam int WIDTH_NB_DEF   = 3;
   localparam int IMG_WIDTH_DEF  = 8;
   localparam int COEF_WIDTH_DEF = 8;
   localparam int MEM_AWIDTH_DEF = 8;
   localparam int TAPS           = HEIGHT_NB_DEF * WIDTH_NB_DEF;

   function automatic int taps_of(input int height_nb, input int width_nb);
      return height_nb * width_nb;
   endfunction

   // Pixel is zero-extended by one bit so it can be treated as signed.
   function automatic int prod_width(input int img_w, input int coef_w);
      return img_w + 1 + coef_w;
   endfunction

   // Growth of $clog2(taps) bits guarantees the adder tree cannot overflow.
   function automatic int sum_width(input int img_w, input int coef_w, input int taps);
      return prod_width(img_w, coef_w) + $clog2(taps);
   endfunction

   // Row 0 is the top (oldest) row, col 0 the oldest column.
   function automatic int tap_index(input int row, input int col, input int width_nb);
      return row * width_nb + col;
   endfunction

endpackage

// File: rtl/window_filter_if.sv
// -----------------------------------------------------------------------------
// window_filter_if
// Streaming bus between the row line buffer, the window filter and its sink.
//   up_data : HEIGHT_NB pixels per beat, slice 0 newest row
//   up_val  : column beat valid (no backpressure)
//   dn_data : filtered pixel
//   dn_val  : dn_data valid, one cycle per result
// Modports: master = upstream producer / downstream consumer side,
//           slave  = the filter itself.
// -----------------------------------------------------------------------------
interface window_filter_if
   import filter_pkg::*;
#(
   parameter int IMG_WIDTH = IMG_WIDTH_DEF,
   parameter int HEIGHT_NB = HEIGHT_NB_DEF
);

   logic [IMG_WIDTH*HEIGHT_NB-1:0] up_data;
   logic                           up_val;
   logic [IMG_WIDTH-1:0]           dn_data;
   logic                           dn_val;

   modport master (
      output up_data,
      output up_val,
      input  dn_data,
      input  dn_val
   );

   modport slave (
      input  up_data,
      input  up_val,
      output dn_data,
      output dn_val
   );

endinterface

// File: rtl/filter_mac.sv
// -----------------------------------------------------------------------------
// filter_mac
// Product and adder-tree stages of the window filter.
//   clk, rst  : clock, asynchronous active-high reset (valids only)
//   vld_p0    : window register holds a fully populated window
//   pix_p0    : flattened window, tap i at [i*IMG_WIDTH +: IMG_WIDTH]
//   coef_p0   : flattened signed coefficients, same tap ordering
//   sum_p2    : signed sum of all products, two cycles after vld_p0
//   vld_p2    : sum_p2 valid
// -----------------------------------------------------------------------------
module filter_mac
   import filter_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int COEF_WIDTH = COEF_WIDTH_DEF,
   parameter int NTAPS      = TAPS,
   parameter int PROD_W     = prod_width(IMG_WIDTH, COEF_WIDTH),
   parameter int SUM_W      = sum_width(IMG_WIDTH, COEF_WIDTH, NTAPS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          vld_p0,
   input  logic [NTAPS*IMG_WIDTH-1:0]    pix_p0,
   input  logic [NTAPS*COEF_WIDTH-1:0]   coef_p0,
   output logic signed [SUM_W-1:0]       sum_p2,
   output logic                          vld_p2
);

   logic signed [PROD_W-1:0] prod_p1_d [NTAPS];
   logic signed [PROD_W-1:0] prod_p1_q [NTAPS];
   logic                     vld_p1_q;
   logic signed [SUM_W-1:0]  sum_p2_d;
   logic signed [SUM_W-1:0]  sum_p2_q;
   logic                     vld_p2_q;

   // ---- stage p0 -> p1 : per-tap signed products ----
   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         prod_p1_d[i] = PROD_W'($signed({1'b0, pix_p0[i*IMG_WIDTH +: IMG_WIDTH]}))
                      * PROD_W'($signed(coef_p0[i*COEF_WIDTH +: COEF_WIDTH]));
      end
   end

   // ---- stage p1 -> p2 : adder tree ----
   always_comb begin
      sum_p2_d = '0;
      for (int i = 0; i < NTAPS; i++) begin
         sum_p2_d = sum_p2_d + SUM_W'(prod_p1_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p0;
         vld_p2_q <= vld_p1_q;
      end
   end

   always_ff @(posedge clk) begin
      prod_p1_q <= prod_p1_d;
      sum_p2_q  <= sum_p2_d;
   end

   assign sum_p2 = sum_p2_q;
   assign vld_p2 = vld_p2_q;

endmodule

// File: rtl/window_filter.sv
// -----------------------------------------------------------------------------
// window_filter
// Sliding HEIGHT_NB x WIDTH_NB convolution stage fed by the row line buffer.
// Column beats shift into the window; every fully populated window produces
// one normalised pixel three cycles after its beat was sampled.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   cfg_width      : pixels per image line (latched on cfg_set)
//   cfg_shift      : arithmetic right shift of the sum (latched on cfg_set)
//   cfg_set        : latch geometry, clear position counters; drops a same-cycle beat
//   cfg_coef       : signed coefficient value
//   cfg_coef_addr  : tap index = row*WIDTH_NB + col
//   cfg_coef_wr    : coefficient write strobe, effective immediately
//   strm (slave)   : up_data/up_val column stream in, dn_data/dn_val out
//
// Build option:
//   FILTER_SAT_EN  : defined   -> shifted sum clamped to [0, 2^IMG_WIDTH-1]
//                    undefined -> low IMG_WIDTH bits of the shifted sum
// -----------------------------------------------------------------------------
module window_filter
   import filter_pkg::*;
#(
   parameter int HEIGHT_NB  = HEIGHT_NB_DEF,
   parameter int WIDTH_NB   = WIDTH_NB_DEF,
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int COEF_WIDTH = COEF_WIDTH_DEF,
   parameter int MEM_AWIDTH = MEM_AWIDTH_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [MEM_AWIDTH-1:0]                  cfg_width,
   input  logic [4:0]                             cfg_shift,
   input  logic                                   cfg_set,
   input  logic signed [COEF_WIDTH-1:0]           cfg_coef,
   input  logic [$clog2(HEIGHT_NB*WIDTH_NB)-1:0]  cfg_coef_addr,
   input  logic                                   cfg_coef_wr,
   window_filter_if.slave                         strm
);

   localparam int NTAPS   = taps_of(HEIGHT_NB, WIDTH_NB);
   localparam int PROD_W  = prod_width(IMG_WIDTH, COEF_WIDTH);
   localparam int SUM_W   = sum_width(IMG_WIDTH, COEF_WIDTH, NTAPS);
   localparam int ROW_W   = (HEIGHT_NB > 1) ? $clog2(HEIGHT_NB) : 1;
   localparam int PIX_MAX = (2 ** IMG_WIDTH) - 1;

   logic [MEM_AWIDTH-1:0]        col_q, col_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic [MEM_AWIDTH-1:0]        width_q, width_d;
   logic [4:0]                   shift_q, shift_d;
   logic [IMG_WIDTH-1:0]         win_q [HEIGHT_NB][WIDTH_NB];
   logic [IMG_WIDTH-1:0]         win_d [HEIGHT_NB][WIDTH_NB];
   logic signed [COEF_WIDTH-1:0] coef_q [NTAPS];
   logic signed [COEF_WIDTH-1:0] coef_d [NTAPS];
   logic                         vld_p0_q, vld_p0_d;
   logic [IMG_WIDTH-1:0]         dn_data_q, dn_data_d;
   logic                         dn_val_q, dn_val_d;

   logic                         beat;
   logic                         col_wrap;
   logic [NTAPS*IMG_WIDTH-1:0]   pix_flat_p0;
   logic [NTAPS*COEF_WIDTH-1:0]  coef_flat_p0;
   logic signed [SUM_W-1:0]      sum_p2;
   logic                         vld_p2;
   logic signed [SUM_W-1:0]      shifted_p2;

   // Output mapping of the shifted sum onto the unsigned pixel range.
   function automatic logic [IMG_WIDTH-1:0] map_pixel(input logic signed [SUM_W-1:0] v);
`ifdef FILTER_SAT_EN
      if (v < 0) begin
         return '0;
      end else if (v > SUM_W'(PIX_MAX)) begin
         return '1;
      end else begin
         return IMG_WIDTH'(v);
      end
`else
      return IMG_WIDTH'(v);
`endif
   endfunction

   // A configuration cycle swallows any beat presented alongside it.
   assign beat     = strm.up_val && !cfg_set;
   assign col_wrap = (col_q == width_q - MEM_AWIDTH'(1));

   // Position counters, window shift and geometry latch.
   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      width_d  = width_q;
      shift_d  = shift_q;
      win_d    = win_q;
      vld_p0_d = 1'b0;

      if (cfg_set) begin
         width_d = cfg_width;
         shift_d = cfg_shift;
         col_d   = '0;
         row_d   = '0;
      end else if (beat) begin
         // Validity is judged on the position this beat lands on, before advancing.
         vld_p0_d = (width_q >= MEM_AWIDTH'(WIDTH_NB))
                 && (col_q >= MEM_AWIDTH'(WIDTH_NB - 1))
                 && (row_q == ROW_W'(HEIGHT_NB - 1));

         if (col_wrap) begin
            col_d = '0;
            if (row_q != ROW_W'(HEIGHT_NB - 1)) begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + MEM_AWIDTH'(1);
         end

         // Newest column enters on the right; bus slice 0 is the bottom (newest) row.
         for (int r = 0; r < HEIGHT_NB; r++) begin
            for (int c = 0; c < WIDTH_NB - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIDTH_NB-1] = strm.up_data[(HEIGHT_NB-1-r)*IMG_WIDTH +: IMG_WIDTH];
         end
      end
   end

   always_comb begin
      coef_d = coef_q;
      if (cfg_coef_wr && (int'(cfg_coef_addr) < NTAPS)) begin
         coef_d[cfg_coef_addr] = cfg_coef;
      end
   end

   always_comb begin
      pix_flat_p0  = '0;
      coef_flat_p0 = '0;
      for (int r = 0; r < HEIGHT_NB; r++) begin
         for (int c = 0; c < WIDTH_NB; c++) begin
            pix_flat_p0[tap_index(r, c, WIDTH_NB)*IMG_WIDTH +: IMG_WIDTH] = win_q[r][c];
         end
      end
      for (int i = 0; i < NTAPS; i++) begin
         coef_flat_p0[i*COEF_WIDTH +: COEF_WIDTH] = coef_q[i];
      end
   end

   // ---- stage p0 : window register, coefficients, counters ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q    <= '0;
         row_q    <= '0;
         width_q  <= '0;
         shift_q  <= '0;
         win_q    <= '{default: '0};
         coef_q   <= '{default: '0};
         vld_p0_q <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         width_q  <= width_d;
         shift_q  <= shift_d;
         win_q    <= win_d;
         coef_q   <= coef_d;
         vld_p0_q <= vld_p0_d;
      end
   end

   // ---- stages p1, p2 : products and adder tree ----
   filter_mac #(
      .IMG_WIDTH  (IMG_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .NTAPS      (NTAPS),
      .PROD_W     (PROD_W),
      .SUM_W      (SUM_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .vld_p0  (vld_p0_q),
      .pix_p0  (pix_flat_p0),
      .coef_p0 (coef_flat_p0),
      .sum_p2  (sum_p2),
      .vld_p2  (vld_p2)
   );

   // ---- stage p3 : normalise and map to output pixel ----
   always_comb begin
      shifted_p2 = sum_p2 >>> shift_q;
      dn_val_d   = vld_p2;
      dn_data_d  = vld_p2 ? map_pixel(shifted_p2) : dn_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn_data_q <= '0;
         dn_val_q  <= 1'b0;
      end else begin
         dn_data_q <= dn_data_d;
         dn_val_q  <= dn_val_d;
      end
   end

   assign strm.dn_data = dn_data_q;
   assign strm.dn_val  = dn_val_q;

endmodule

// File: tb/tb_window_filter.sv
// -----------------------------------------------------------------------------
// tb_window_filter
// Self-checking bench for window_filter. A behavioural model keeps the history
// of accepted columns and the beat count since the last cfg_set, derives window
// validity from line position arithmetic and computes each expected pixel
// directly as a weighted sum. Honours FILTER_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_window_filter;
   import filter_pkg::*;

   localparam int H  = 3;
   localparam int W  = 3;
   localparam int IW = 8;
   localparam int CW = 8;
   localparam int AW = 8;
   localparam int NT = TAPS;
   localparam int CA = $clog2(NT);

`ifdef FILTER_SAT_EN
   localparam int SAT_HI = 255;
   localparam int SAT_LO = 0;
`else
   localparam int SAT_HI = 247;
   localparam int SAT_LO = 251;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [AW-1:0]        cfg_width;
   logic [4:0]           cfg_shift;
   logic                 cfg_set;
   logic signed [CW-1:0] cfg_coef;
   logic [CA-1:0]        cfg_coef_addr;
   logic                 cfg_coef_wr;

   window_filter_if #(.IMG_WIDTH(IW), .HEIGHT_NB(H)) bus ();

   window_filter #(
      .HEIGHT_NB  (H),
      .WIDTH_NB   (W),
      .IMG_WIDTH  (IW),
      .COEF_WIDTH (CW),
      .MEM_AWIDTH (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_width     (cfg_width),
      .cfg_shift     (cfg_shift),
      .cfg_set       (cfg_set),
      .cfg_coef      (cfg_coef),
      .cfg_coef_addr (cfg_coef_addr),
      .cfg_coef_wr   (cfg_coef_wr),
      .strm          (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int due;
      int raw;
   } exp_t;

   logic [IW*H-1:0] hist [$];
   int              m_coef [NT];
   int              m_width;
   int              m_shift;
   int              m_beats;
   exp_t            pend [$];
   int              obs [$];
   int              first_out;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   function automatic int map_out(input int raw, input int sh);
      int v;
      v = raw >>> sh;
`ifdef FILTER_SAT_EN
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
`else
      return v & 255;
`endif
   endfunction

   function automatic int window_sum();
      int              s;
      int              px;
      logic [IW*H-1:0] cv;
      s = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            cv = hist[hist.size() - W + c];
            px = int'(cv[(H-1-r)*IW +: IW]);
            s += m_coef[r*W + c] * px;
         end
      end
      return s;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < W; i++) hist.push_back('0);
      for (int i = 0; i < NT; i++) m_coef[i] = 0;
      m_width = 0;
      m_shift = 0;
      m_beats = 0;
      pend.delete();
   endtask

   // One clock: model consumes what the DUT samples, then outputs are checked.
   task automatic step();
      int   old_shift;
      bit   wv;
      bit   exp_v;
      exp_t e;
      @(posedge clk);
      cyc++;
      old_shift = m_shift;
      if (!rst) begin
         if (cfg_coef_wr && (int'(cfg_coef_addr) < NT)) m_coef[cfg_coef_addr] = int'(cfg_coef);
         if (cfg_set) begin
            m_width = int'(cfg_width);
            m_shift = int'(cfg_shift);
            m_beats = 0;
         end else if (bus.up_val) begin
            wv = 1'b0;
            if (m_width >= W) wv = ((m_beats % m_width) >= W - 1) && ((m_beats / m_width) >= H - 1);
            hist.push_back(bus.up_data);
            void'(hist.pop_front());
            if (wv) begin
               e.due = cyc + 3;
               e.raw = window_sum();
               pend.push_back(e);
            end
            m_beats++;
         end
      end
      @(negedge clk);
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      check("dn_val", {31'b0, bus.dn_val}, {31'b0, exp_v});
      if (exp_v) begin
         check("dn_data", {24'b0, bus.dn_data}, 32'(map_out(pend[0].raw, old_shift)));
         void'(pend.pop_front());
      end
      if (bus.dn_val === 1'b1) begin
         obs.push_back(int'(bus.dn_data));
         if (first_out < 0) first_out = cyc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic beat(input logic [IW*H-1:0] d);
      bus.up_val  = 1'b1;
      bus.up_data = d;
      step();
      bus.up_val  = 1'b0;
   endtask

   task automatic wr_coef(input int a, input int v);
      cfg_coef_addr = CA'(a);
      cfg_coef      = CW'(v);
      cfg_coef_wr   = 1'b1;
      step();
      cfg_coef_wr   = 1'b0;
   endtask

   task automatic set_cfg(input int w, input int sh);
      cfg_width = AW'(w);
      cfg_shift = 5'(sh);
      cfg_set   = 1'b1;
      step();
      cfg_set   = 1'b0;
   endtask

   function automatic logic [IW*H-1:0] col3(input int v);
      logic [IW-1:0] p;
      p = IW'(v);
      return {H{p}};
   endfunction

   task automatic check_obs(input string tag, input int exp_q [$]);
      check({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs.size()) check({tag, "_value"}, 32'(obs[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int beat22;
      int exp_q [$];

      rst           = 1'b1;
      cfg_width     = '0;
      cfg_shift     = '0;
      cfg_set       = 1'b0;
      cfg_coef      = '0;
      cfg_coef_addr = '0;
      cfg_coef_wr   = 1'b0;
      bus.up_val    = 1'b0;
      bus.up_data   = '0;
      first_out     = -1;
      model_reset();

      // Reset state
      @(negedge clk);
      check("rst_dn_val", {31'b0, bus.dn_val}, 32'd0);
      check("rst_dn_data", {24'b0, bus.dn_data}, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(2);

      // Identity: centre tap only, width 10, column k carries k+1
      for (int t = 0; t < NT; t++) wr_coef(t, (t == 4) ? 1 : 0);
      set_cfg(10, 0);
      obs.delete();
      first_out = -1;
      beat22 = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 22) beat22 = cyc + 1;
         beat(col3(i % 10 + 1));
      end
      idle(4);
      exp_q = {2, 3, 4, 5, 6, 7, 8, 9};
      check_obs("identity", exp_q);
      check("identity_latency", 32'(first_out - beat22), 32'd3);

      // Same stream with a gap after every beat
      set_cfg(10, 0);
      obs.delete();
      for (int i = 0; i < 30; i++) begin
         beat(col3(i % 10 + 1));
         idle(1);
      end
      idle(4);
      check_obs("gaps", exp_q);

      // Box filter
      for (int t = 0; t < NT; t++) wr_coef(t, 1);
      set_cfg(10, 3);
      obs.delete();
      for (int i = 0; i < 30; i++) beat(col3(16));
      idle(4);
      exp_q = {18, 18, 18, 18, 18, 18, 18, 18};
      check_obs("box", exp_q);

      // Saturation, high side
      set_cfg(4, 0);
      obs.delete();
      for (int i = 0; i < 12; i++) beat(col3(255));
      idle(4);
      exp_q = {SAT_HI, SAT_HI};
      check_obs("sat_hi", exp_q);

      // Saturation, low side
      for (int t = 0; t < NT; t++) wr_coef(t, (t == 4) ? -1 : 0);
      set_cfg(4, 0);
      obs.delete();
      for (int i = 0; i < 12; i++) beat(col3(5));
      idle(4);
      exp_q = {SAT_LO, SAT_LO};
      check_obs("sat_lo", exp_q);

      // cfg_set mid-line together with a beat
      for (int t = 0; t < NT; t++) wr_coef(t, (t == 4) ? 1 : 0);
      set_cfg(10, 0);
      for (int i = 0; i < 24; i++) beat(col3(i % 10 + 1));
      obs.delete();
      cfg_width = AW'(8);
      cfg_shift = 5'd0;
      cfg_set   = 1'b1;
      beat(col3(5));
      cfg_set   = 1'b0;
      for (int i = 0; i < 24; i++) beat(col3(i % 8 + 1));
      idle(4);
      exp_q = {2, 3, 2, 3, 4, 5, 6, 7};
      check_obs("cfg_midline", exp_q);

      // Randomised segments with mid-stream coefficient writes and reconfiguration
      for (int seg = 0; seg < 5; seg++) begin
         for (int t = 0; t < NT; t++) wr_coef(t, int'($urandom_range(0, 255)));
         set_cfg(int'($urandom_range(2, 9)), int'($urandom_range(0, 10)));
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
               cfg_coef_addr = CA'($urandom_range(0, NT - 1));
               cfg_coef      = CW'($urandom_range(0, 255));
               cfg_coef_wr   = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
               cfg_width = AW'($urandom_range(3, 8));
               cfg_shift = 5'($urandom_range(0, 10));
               cfg_set   = 1'b1;
            end
            bus.up_val  = ($urandom_range(0, 9) < 7);
            bus.up_data = (IW*H)'($urandom);
            step();
            bus.up_val  = 1'b0;
            cfg_coef_wr = 1'b0;
            cfg_set     = 1'b0;
         end
         idle(4);
      end

      // Asynchronous reset in the middle of a stream
      set_cfg(5, 0);
      for (int i = 0; i < 14; i++) beat(col3(i % 5 + 1));
      #2 rst = 1'b1;
      #1;
      check("async_rst_dn_val", {31'b0, bus.dn_val}, 32'd0);
      check("async_rst_dn_data", {24'b0, bus.dn_data}, 32'd0);
      model_reset();
      idle(2);
      rst = 1'b0;
      wr_coef(4, 1);
      set_cfg(5, 0);
      obs.delete();
      for (int i = 0; i < 13; i++) beat(col3(i % 5 + 1));
      check("post_rst_quiet", 32'(obs.size()), 32'd0);
      for (int i = 13; i < 15; i++) beat(col3(i % 5 + 1));
      idle(4);
      exp_q = {2, 3, 4};
      check_obs("post_rst", exp_q);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
